// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and the data stage.
// Accesses are serialised: grant in IDLE, one-cycle strobe in ISSUE, read latency in WAIT, done pulse in RESP.
module mem_port_arbiter #(
  parameter int READ_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_done,
  output logic [31:0] dm_rdata,
  output logic        bus_en,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  output logic        pipe_stall
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic {FETCH = 1'b0, DATA = 1'b1} owner_t;

  state_t      state_q, state_d;
  owner_t      owner_q, owner_d;
  owner_t      last_owner_q, last_owner_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        bus_en_q, bus_en_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic        if_done_q, if_done_d;
  logic        dm_done_q, dm_done_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;
  logic        grant_data;

  // Data wins a tie unless it had the previous grant.
  assign grant_data = dm_req & (~if_req | (last_owner_q == FETCH));

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    bus_en_d     = 1'b0;
    bus_we_d     = 1'b0;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    if_done_d    = 1'b0;
    dm_done_d    = 1'b0;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (if_req | dm_req) begin
          owner_d      = grant_data ? DATA : FETCH;
          last_owner_d = grant_data ? DATA : FETCH;
          bus_en_d     = 1'b1;
          bus_we_d     = grant_data & dm_we;
          bus_addr_d   = grant_data ? dm_addr : if_addr;
          bus_wdata_d  = grant_data ? dm_wdata : bus_wdata_q;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (bus_we_q) begin
          dm_done_d = (owner_q == DATA);
          if_done_d = (owner_q == FETCH);
          state_d   = RESP;
        end else begin
          cnt_d   = 4'(READ_LAT);
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // Last wait cycle: bus_rdata is valid READ_LAT cycles after the strobe.
        if (cnt_q == 4'd1) begin
          if (owner_q == DATA) begin
            dm_rdata_d = bus_rdata;
            dm_done_d  = 1'b1;
          end else begin
            if_rdata_d = bus_rdata;
            if_done_d  = 1'b1;
          end
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= FETCH;
      last_owner_q <= FETCH;
      cnt_q        <= '0;
      bus_en_q     <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      if_done_q    <= 1'b0;
      dm_done_q    <= 1'b0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      bus_en_q     <= bus_en_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      if_done_q    <= if_done_d;
      dm_done_q    <= dm_done_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
    end
  end

  assign if_done    = if_done_q;
  assign if_rdata   = if_rdata_q;
  assign dm_done    = dm_done_q;
  assign dm_rdata   = dm_rdata_q;
  assign bus_en     = bus_en_q;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;
  assign pipe_stall = ~rst & ((if_req & ~if_done_q) | (dm_req & ~dm_done_q));

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the 5-stage core.
- Serialises requests and drives the memory bus with registered outputs.
- Returns read data with a one-cycle done pulse per access.
- Provides a combinational stall to the hazard unit while any request is outstanding.

Parameters:
- READ_LAT, 2, cycles from the bus_en cycle to valid bus_rdata; legal range 1..15.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- if_req  in  1  fetch read request; held until if_done
- if_addr  in  32  fetch address
- if_done  out  1  one-cycle pulse, fetch access complete
- if_rdata  out  32  instruction word; valid while if_done=1
- dm_req  in  1  data request; held until dm_done
- dm_we  in  1  1=store, 0=load
- dm_addr  in  32  data address
- dm_wdata  in  32  store data
- dm_done  out  1  one-cycle pulse, data access complete
- dm_rdata  out  32  load data; valid while dm_done=1 and the access was a load
- bus_en  out  1  memory access strobe, exactly one cycle per access
- bus_we  out  1  write enable, qualified by bus_en
- bus_addr  out  32  memory address
- bus_wdata  out  32  memory write data
- bus_rdata  in  32  memory read data
- pipe_stall  out  1  to hazard unit: (if_req & ~if_done) | (dm_req & ~dm_done); forced 0 while rst=1

Behaviour:
- State machine has four states: IDLE, ISSUE, WAIT, RESP.
- Reset values: state=IDLE, last_owner=FETCH, all outputs 0, counter 0.

IDLE
- If either request is pending, choose an owner and latch owner, addr, we and wdata (fetch always latches we=0), then go to ISSUE.
- Arbitration when only one request is pending: that requester wins.
- Arbitration when both are pending: DATA wins unless last_owner=DATA, in which case FETCH wins (round-robin).
- last_owner updates at grant.

ISSUE
- bus_en=1 for this cycle only; bus_addr, bus_we and bus_wdata are driven from the latches.
- Store: go to RESP.
- Load or fetch: counter=READ_LAT, go to WAIT.

WAIT
- counter decrements each cycle.
- bus_rdata is sampled into the owner's rdata register at the edge that ends the cycle READ_LAT cycles after the ISSUE cycle.
- Then go to RESP.

RESP
- The owner's done=1 for exactly one cycle; the other done stays 0.
- Then go to IDLE.
- No new grant is made in RESP, so a request still held during its done cycle is not re-served.

Timing and data rules
- Timing, with the request first seen in IDLE at cycle N:
  - bus_en in cycle N+1
  - load/fetch done in cycle N+2+READ_LAT
  - store done in cycle N+2
- Minimum gap between consecutive accesses is the RESP and IDLE cycles; the next bus_en is 2 cycles after a done.
- bus_addr, bus_we and bus_wdata hold their values outside bus_en; bus_we is 0 except during a store's bus_en.
- if_rdata and dm_rdata hold their last captured value after done.
- dm_rdata is unchanged by stores.

Boundary and reset conditions
- A request that drops before its grant is ignored.
- A request that drops after its grant is still completed; done pulses regardless.
- Reset mid-access (ISSUE, WAIT or RESP): next cycle is IDLE, no done pulse, bus_en=0, captured data cleared.
- A store already strobed on the bus is not retracted.

Test Plan:
- Fetch read, READ_LAT=2: if_req=1, if_addr=0x100 at cycle 0; memory returns 0xDEADBEEF in cycle 3 -> bus_en=1/bus_we=0/bus_addr=0x100 in cycle 1 only; if_done=1, if_rdata=0xDEADBEEF in cycle 4; pipe_stall=1 in cycles 0-3.
- Store: dm_req=1, dm_we=1, dm_addr=0x200, dm_wdata=0x12345678 at cycle 0 -> bus_en=1/bus_we=1/bus_addr=0x200/bus_wdata=0x12345678 in cycle 1; dm_done in cycle 2; dm_rdata unchanged.
- Contention, after reset: if_req and dm_req both held from cycle 0 -> DATA served first (bus_en cycle 1). FETCH granted next, bus_en in cycle 6 with READ_LAT=2 load. With both still pending after that, next grant goes to DATA.
- Held request: if_req held high through and after if_done -> exactly one bus_en per done; no duplicate access during RESP.
- Reset in WAIT: assert rst for 1 cycle in cycle 2 of a fetch -> no if_done; outputs 0; a fresh if_req afterwards is served with nominal latency.
- READ_LAT=1 build: fetch of 0x4 returning 0x00000013 -> bus_en cycle 1, if_done with 0x00000013 in cycle 3.
